// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (F) and memory-stage (M) requesters.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef ARB_PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InstrReqF,
  input  logic [ADDR_W-1:0] InstrAddrF,
  output logic [DATA_W-1:0] InstrRdataF,
  output logic              InstrReadyF,
  input  logic              DataReqM,
  input  logic              DataWeM,
  input  logic [ADDR_W-1:0] DataAddrM,
  input  logic [DATA_W-1:0] DataWdataM,
  output logic [DATA_W-1:0] DataRdataM,
  output logic              DataReadyM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemAck,
  output logic              StallF,
  output logic              StallM
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  ConflictCnt,
  output logic [CNT_W-1:0]  BusyCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_r;
  logic   starve_r;

  // M wins ties unless F was already passed over once
  logic grant_d_s;
  assign grant_d_s = DataReqM & (~InstrReqF | ~starve_r);

  assign StallF = InstrReqF & ~InstrReadyF;
  assign StallM = DataReqM & ~DataReadyM;

  // Arbitration FSM with registered memory-side and ready outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      starve_r    <= 1'b0;
      MemReq      <= 1'b0;
      MemWe       <= 1'b0;
      MemAddr     <= {ADDR_W{1'b0}};
      MemWdata    <= {DATA_W{1'b0}};
      InstrRdataF <= {DATA_W{1'b0}};
      InstrReadyF <= 1'b0;
      DataRdataM  <= {DATA_W{1'b0}};
      DataReadyM  <= 1'b0;
    end else begin
      InstrReadyF <= 1'b0;
      DataReadyM  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            state_r  <= BUSY_D;
            MemReq   <= 1'b1;
            MemWe    <= DataWeM;
            MemAddr  <= DataAddrM;
            MemWdata <= DataWdataM;
            starve_r <= starve_r | InstrReqF;
          end else if (InstrReqF) begin
            state_r  <= BUSY_I;
            MemReq   <= 1'b1;
            MemWe    <= 1'b0;
            MemAddr  <= InstrAddrF;
            MemWdata <= {DATA_W{1'b0}};
            starve_r <= 1'b0;
          end else begin
            state_r  <= IDLE;
          end
        end
        BUSY_I: begin
          if (MemAck) begin
            MemReq      <= 1'b0;
            InstrRdataF <= MemRdata;
            InstrReadyF <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= BUSY_I;
          end
        end
        BUSY_D: begin
          if (MemAck) begin
            MemReq     <= 1'b0;
            DataRdataM <= MemRdata;
            DataReadyM <= 1'b1;
            state_r    <= DONE;
          end else begin
            state_r    <= BUSY_D;
          end
        end
        DONE: begin
          // turnaround cycle lets the requester drop or change its request
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          MemReq  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating conflict and busy-cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ConflictCnt <= {CNT_W{1'b0}};
      BusyCnt     <= {CNT_W{1'b0}};
    end else begin
      if (InstrReqF && DataReqM && (state_r == IDLE) && (ConflictCnt != CNT_MAX)) begin
        ConflictCnt <= ConflictCnt + CNT_ONE;
      end else begin
        ConflictCnt <= ConflictCnt;
      end
      if (((state_r == BUSY_I) || (state_r == BUSY_D)) && (BusyCnt != CNT_MAX)) begin
        BusyCnt <= BusyCnt + CNT_ONE;
      end else begin
        BusyCnt <= BusyCnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a fixed-latency memory model
// (ack 2 cycles after MemReq rises, read data = address ^ 32'hA5A5A5A5).
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              InstrReqF;
  logic [ADDR_W-1:0] InstrAddrF;
  logic [DATA_W-1:0] InstrRdataF;
  logic              InstrReadyF;
  logic              DataReqM;
  logic              DataWeM;
  logic [ADDR_W-1:0] DataAddrM;
  logic [DATA_W-1:0] DataWdataM;
  logic [DATA_W-1:0] DataRdataM;
  logic              DataReadyM;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              MemAck;
  logic              StallF;
  logic              StallM;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]       ConflictCnt;
  logic [15:0]       BusyCnt;
`endif

  int n_cmp;
  int n_err;
  int mem_cnt;
  int spur_req_cnt;
  int spur_done_cnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .InstrReqF   (InstrReqF),
    .InstrAddrF  (InstrAddrF),
    .InstrRdataF (InstrRdataF),
    .InstrReadyF (InstrReadyF),
    .DataReqM    (DataReqM),
    .DataWeM     (DataWeM),
    .DataAddrM   (DataAddrM),
    .DataWdataM  (DataWdataM),
    .DataRdataM  (DataRdataM),
    .DataReadyM  (DataReadyM),
    .MemReq      (MemReq),
    .MemWe       (MemWe),
    .MemAddr     (MemAddr),
    .MemWdata    (MemWdata),
    .MemRdata    (MemRdata),
    .MemAck      (MemAck),
    .StallF      (StallF),
    .StallM      (StallM)
`ifdef ARB_PERF_CNT_EN
    ,
    .ConflictCnt (ConflictCnt),
    .BusyCnt     (BusyCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack sampled on the third rising edge after MemReq is first seen,
  // plus on-demand spurious acks requested by the stimulus process.
  initial begin
    MemAck        = 1'b0;
    MemRdata      = 32'h0000_0000;
    mem_cnt       = 0;
    spur_done_cnt = 0;
  end
  always @(negedge clk) begin
    if (MemAck) begin
      MemAck = 1'b0;
    end else if (spur_done_cnt != spur_req_cnt) begin
      spur_done_cnt = spur_done_cnt + 1;
      MemAck   = 1'b1;
      MemRdata = 32'hFFFF_0000;
    end else if (MemReq) begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt == 3) begin
        MemAck   = 1'b1;
        MemRdata = MemAddr ^ 32'hA5A5_A5A5;
        mem_cnt  = 0;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    spur_req_cnt = 0;
    rst = 1'b0;
    InstrReqF = 1'b0; InstrAddrF = 32'h0; DataReqM = 1'b0; DataWeM = 1'b0;
    DataAddrM = 32'h0; DataWdataM = 32'h0;

    // 1: reset and idle
    tick(3);
    rst = 1'b1;
    tick(2);
    check_value("t1_memreq", {63'd0, MemReq}, 64'd0);
    check_value("t1_readyf", {63'd0, InstrReadyF}, 64'd0);
    check_value("t1_readym", {63'd0, DataReadyM}, 64'd0);
    check_value("t1_stallf", {63'd0, StallF}, 64'd0);
    check_value("t1_stallm", {63'd0, StallM}, 64'd0);
`ifdef ARB_PERF_CNT_EN
    check_value("t1_conflict", {48'd0, ConflictCnt}, 64'd0);
    check_value("t1_busy", {48'd0, BusyCnt}, 64'd0);
`endif

    // 2: single fetch
    InstrReqF = 1'b1; InstrAddrF = 32'h0000_0040;
    #1;
    check_value("t2_stallf_c0", {63'd0, StallF}, 64'd1);
    check_value("t2_memreq_c0", {63'd0, MemReq}, 64'd0);
    tick(1);
    check_value("t2_memreq_c1", {63'd0, MemReq}, 64'd1);
    check_value("t2_addr_c1", {32'd0, MemAddr}, 64'h40);
    check_value("t2_we_c1", {63'd0, MemWe}, 64'd0);
    tick(2);
    check_value("t2_stallf_c3", {63'd0, StallF}, 64'd1);
    check_value("t2_readyf_c3", {63'd0, InstrReadyF}, 64'd0);
    tick(1);
    check_value("t2_readyf_c4", {63'd0, InstrReadyF}, 64'd1);
    check_value("t2_rdataf_c4", {32'd0, InstrRdataF}, 64'hA5A5_A5E5);
    check_value("t2_stallf_c4", {63'd0, StallF}, 64'd0);
    check_value("t2_memreq_c4", {63'd0, MemReq}, 64'd0);
    InstrReqF = 1'b0;
    tick(1);
    check_value("t2_readyf_c5", {63'd0, InstrReadyF}, 64'd0);

    // 3: simultaneous requests, M write goes first
    InstrReqF = 1'b1; InstrAddrF = 32'h0000_0080;
    DataReqM = 1'b1; DataWeM = 1'b1; DataAddrM = 32'h0000_0100; DataWdataM = 32'hDEAD_BEEF;
    tick(1);
    check_value("t3_addr_c1", {32'd0, MemAddr}, 64'h100);
    check_value("t3_we_c1", {63'd0, MemWe}, 64'd1);
    check_value("t3_wdata_c1", {32'd0, MemWdata}, 64'hDEAD_BEEF);
    tick(3);
    check_value("t3_readym_c4", {63'd0, DataReadyM}, 64'd1);
    check_value("t3_readyf_c4", {63'd0, InstrReadyF}, 64'd0);
    check_value("t3_stallm_c4", {63'd0, StallM}, 64'd0);
    check_value("t3_stallf_c4", {63'd0, StallF}, 64'd1);
    DataReqM = 1'b0; DataWeM = 1'b0;
    tick(1);
    check_value("t3_memreq_c5", {63'd0, MemReq}, 64'd0);
    check_value("t3_readym_c5", {63'd0, DataReadyM}, 64'd0);
    tick(1);
    check_value("t3_memreq_c6", {63'd0, MemReq}, 64'd1);
    check_value("t3_addr_c6", {32'd0, MemAddr}, 64'h80);
    check_value("t3_we_c6", {63'd0, MemWe}, 64'd0);
    tick(3);
    check_value("t3_readyf_c9", {63'd0, InstrReadyF}, 64'd1);
    check_value("t3_rdataf_c9", {32'd0, InstrRdataF}, 64'hA5A5_A525);
    check_value("t3_readym_c9", {63'd0, DataReadyM}, 64'd0);
    InstrReqF = 1'b0;
    tick(2);

    // 4: both held high -> grants alternate D, I, D, I
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h0000_0200;
    InstrReqF = 1'b1; InstrAddrF = 32'h0000_0300;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      if ((k % 2) == 0) begin
        check_value("t4_grant_d_addr", {32'd0, MemAddr}, 64'h200);
        tick(3);
        check_value("t4_readym", {63'd0, DataReadyM}, 64'd1);
        check_value("t4_readyf_quiet", {63'd0, InstrReadyF}, 64'd0);
        check_value("t4_rdatam", {32'd0, DataRdataM}, 64'hA5A5_A7A5);
      end else begin
        check_value("t4_grant_i_addr", {32'd0, MemAddr}, 64'h300);
        tick(3);
        check_value("t4_readyf", {63'd0, InstrReadyF}, 64'd1);
        check_value("t4_readym_quiet", {63'd0, DataReadyM}, 64'd0);
        check_value("t4_rdataf", {32'd0, InstrRdataF}, 64'hA5A5_A6A5);
      end
      if (k < 3) tick(2);
    end
    DataReqM = 1'b0; InstrReqF = 1'b0;
    tick(1);
    check_value("t4_memreq_end", {63'd0, MemReq}, 64'd0);

    // 5: spurious ack in IDLE, then a real read
    spur_req_cnt = spur_req_cnt + 1;
    tick(1);
    check_value("t5_readyf_spur", {63'd0, InstrReadyF}, 64'd0);
    check_value("t5_readym_spur", {63'd0, DataReadyM}, 64'd0);
    check_value("t5_memreq_spur", {63'd0, MemReq}, 64'd0);
    tick(1);
    check_value("t5_readym_spur2", {63'd0, DataReadyM}, 64'd0);
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h0000_0044;
    tick(1);
    check_value("t5_memreq_c1", {63'd0, MemReq}, 64'd1);
    tick(3);
    check_value("t5_readym_c4", {63'd0, DataReadyM}, 64'd1);
    check_value("t5_rdatam_c4", {32'd0, DataRdataM}, 64'hA5A5_A5E1);
    DataReqM = 1'b0;
    tick(1);

    // 6: reset during a data write, then a late ack
    DataReqM = 1'b1; DataWeM = 1'b1; DataAddrM = 32'h0000_0500; DataWdataM = 32'h1234_5678;
    tick(1);
    check_value("t6_memreq_c1", {63'd0, MemReq}, 64'd1);
    tick(1);
    check_value("t6_stallm_c2", {63'd0, StallM}, 64'd1);
    rst = 1'b0;
    #1;
    check_value("t6_memreq_rst", {63'd0, MemReq}, 64'd0);
    check_value("t6_we_rst", {63'd0, MemWe}, 64'd0);
    DataReqM = 1'b0; DataWeM = 1'b0;
    #1;
    check_value("t6_stallm_drop", {63'd0, StallM}, 64'd0);
    tick(1);
    rst = 1'b1;
    spur_req_cnt = spur_req_cnt + 1;
    tick(1);
    check_value("t6_readym_ack", {63'd0, DataReadyM}, 64'd0);
    tick(1);
    check_value("t6_readym_ack2", {63'd0, DataReadyM}, 64'd0);
    check_value("t6_memreq_idle", {63'd0, MemReq}, 64'd0);
`ifdef ARB_PERF_CNT_EN
    check_value("t6_conflict", {48'd0, ConflictCnt}, 64'd0);
    check_value("t6_busy", {48'd0, BusyCnt}, 64'd0);
`endif
    InstrReqF = 1'b1; InstrAddrF = 32'h0000_0008;
    tick(1);
    check_value("t6_post_memreq", {63'd0, MemReq}, 64'd1);
    check_value("t6_post_addr", {32'd0, MemAddr}, 64'h8);
    tick(3);
    check_value("t6_post_readyf", {63'd0, InstrReadyF}, 64'd1);
    check_value("t6_post_rdataf", {32'd0, InstrRdataF}, 64'hA5A5_A5AD);
    InstrReqF = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
